// File: rtl/sig_period_monitor.sv
`timescale 1ns/1ps
// Purpose: measures clk cycles between rising edges of sig_in and checks each period against exp_period +/- tolerance.
// Latency: sig_in rise captured at clk edge k -> meas_valid/period_err high in cycle k+SYNC_STAGES+1.
// Backpressure: none; results are one-cycle pulses, the last period is held in meas_period.
module sig_period_monitor #(
  parameter int CNT_W       = 16,
  parameter int ERR_CNT_W   = 8,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_N      = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 clr_err,
  input  logic                 sig_in,
  input  logic [CNT_W-1:0]     exp_period,
  input  logic [CNT_W-1:0]     tolerance,
  output logic [CNT_W-1:0]     meas_period,
  output logic                 meas_valid,
  output logic                 period_err,
  output logic                 timeout,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 locked
);

  localparam int                LOCK_W   = $clog2(LOCK_N + 1);
  localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_N);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_dly_q;
  logic                   edge_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [LOCK_W-1:0]      lock_cnt_q;
  logic [CNT_W:0]         diff;
  logic                   out_of_tol;
  logic                   meas_evt;
  logic                   tmo_evt;
  logic                   tmo_clr;
  logic                   err_evt;

  // Synchronize sig_in and register its rising edge; the edge register keeps the
  // detect path short and sets the overall latency.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q     <= '0;
      sync_dly_q <= 1'b0;
      edge_q     <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], sig_in};
      sync_dly_q <= sync_q[SYNC_STAGES-1];
      edge_q     <= sync_q[SYNC_STAGES-1] & ~sync_dly_q;
    end
  end

  // Absolute deviation from the expected period, one bit wider so it never wraps.
  always_comb begin
    diff = '0;
    if (cnt_q >= exp_period) diff = {1'b0, cnt_q} - {1'b0, exp_period};
    else                     diff = {1'b0, exp_period} - {1'b0, cnt_q};
  end

  assign out_of_tol = (diff > {1'b0, tolerance});
  assign err_evt    = (meas_evt & out_of_tol) | tmo_evt;

  // FSM state and period counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, counter update and measurement/timeout events; enable=0 overrides all.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    meas_evt = 1'b0;
    tmo_evt  = 1'b0;
    tmo_clr  = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: state_d = ARM;
        ARM: begin
          if (edge_q) begin
            state_d = MEASURE;
            cnt_d   = CNT_W'(1);
            tmo_clr = 1'b1;
          end
        end
        MEASURE: begin
          if (edge_q) begin
            meas_evt = 1'b1;
            cnt_d    = CNT_W'(1);
          end else if (cnt_q == CNT_MAX) begin
            state_d = ARM;
            tmo_evt = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Measurement outputs and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meas_period <= '0;
      meas_valid  <= 1'b0;
      period_err  <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      meas_valid <= meas_evt;
      period_err <= meas_evt & out_of_tol;
      if (meas_evt) meas_period <= cnt_q;
      if (!enable || tmo_clr) timeout <= 1'b0;
      else if (tmo_evt)       timeout <= 1'b1;
    end
  end

  // Saturating error counter; a clear coinciding with an error leaves exactly one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (clr_err) begin
      err_count <= err_evt ? ERR_CNT_W'(1) : '0;
    end else if (err_evt && (err_count != ERR_MAX)) begin
      err_count <= err_count + ERR_CNT_W'(1);
    end
  end

  // Consecutive in-tolerance run length, restarted by any error or disable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_cnt_q <= '0;
    end else if (!enable || err_evt) begin
      lock_cnt_q <= '0;
    end else if (meas_evt && (lock_cnt_q != LOCK_MAX)) begin
      lock_cnt_q <= lock_cnt_q + LOCK_W'(1);
    end
  end

  assign locked = (lock_cnt_q == LOCK_MAX);

endmodule

// File: tb/tb_sig_period_monitor.sv
`timescale 1ns/1ps
// Directed bench for sig_period_monitor: nominal, tolerance, timeout, error
// counter saturation/clear, enable/reset mid-period, asynchronous phase.
module tb_sig_period_monitor;

  localparam int CNT_W     = 8;
  localparam int ERR_CNT_W = 2;

  logic                 clk = 1'b0;
  logic                 rst_n, enable, clr_err, sig_in;
  logic [CNT_W-1:0]     exp_period, tolerance, meas_period;
  logic                 meas_valid, period_err, timeout, locked;
  logic [ERR_CNT_W-1:0] err_count;

  int n_chk = 0, n_pass = 0;
  int mv_cnt = 0, pe_cnt = 0, bad_pe = 0, x_seen = 0;
  int rp_cnt = 0, rp_min = 1000, rp_max = 0;
  int mv0, pe0;
  logic [CNT_W-1:0] last_meas = '0;
  logic lock_at_pe = 1'b1;
  bit mon_on = 1'b0, rp_on = 1'b0;

  always #5 clk = ~clk;

  sig_period_monitor #(
    .CNT_W(CNT_W), .ERR_CNT_W(ERR_CNT_W), .SYNC_STAGES(2), .LOCK_N(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clr_err(clr_err), .sig_in(sig_in),
    .exp_period(exp_period), .tolerance(tolerance), .meas_period(meas_period),
    .meas_valid(meas_valid), .period_err(period_err), .timeout(timeout),
    .err_count(err_count), .locked(locked)
  );

  // Observe outputs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (mon_on) begin
      if ($isunknown({meas_period, meas_valid, period_err, timeout, err_count, locked})) x_seen++;
      if (meas_valid) begin
        mv_cnt++;
        last_meas = meas_period;
        if (rp_on) begin
          rp_cnt++;
          if (int'(meas_period) < rp_min) rp_min = int'(meas_period);
          if (int'(meas_period) > rp_max) rp_max = int'(meas_period);
        end
      end
      if (period_err) begin
        pe_cnt++;
        lock_at_pe = locked;
        if (!meas_valid) bad_pe++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // One sig_in period of n clk cycles, rising at its start.
  task automatic period(input int n);
    sig_in = 1'b1;
    repeat (n / 2) tick();
    sig_in = 1'b0;
    repeat (n - n / 2) tick();
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; clr_err = 1'b0; sig_in = 1'b0;
    exp_period = 8'd10; tolerance = 8'd0;
    repeat (3) tick();
    chk("rst_meas_period", 32'(meas_period), 0);
    chk("rst_meas_valid", 32'(meas_valid), 0);
    chk("rst_period_err", 32'(period_err), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_err_count", 32'(err_count), 0);
    chk("rst_locked", 32'(locked), 0);
    rst_n = 1'b1;
    mon_on = 1'b1;
    tick();
    enable = 1'b1;
    repeat (2) tick();

    // Nominal: period 10, exact match, lock on the 4th measurement.
    repeat (4) period(10);
    chk("nom_mv_3", 32'(mv_cnt), 3);
    chk("nom_unlocked_3", 32'(locked), 0);
    period(10);
    chk("nom_mv_4", 32'(mv_cnt), 4);
    chk("nom_locked_4", 32'(locked), 1);
    chk("nom_meas", 32'(last_meas), 10);
    chk("nom_no_err", 32'(pe_cnt), 0);
    chk("nom_err_count", 32'(err_count), 0);

    // Latency: rise set just after edge p is captured at p+1; result after edge p+4.
    sig_in = 1'b1;
    repeat (3) tick();
    chk("lat_early", 32'(meas_valid), 0);
    tick();
    chk("lat_valid", 32'(meas_valid), 1);
    chk("lat_meas", 32'(meas_period), 10);
    chk("lat_no_err", 32'(period_err), 0);
    tick();
    chk("lat_one_cycle", 32'(meas_valid), 0);
    sig_in = 1'b0;
    repeat (5) tick();

    // Out of tolerance: one period of 13 with tolerance 2.
    tolerance = 8'd2;
    period(13);
    chk("oot_locked_before", 32'(locked), 1);
    pe0 = pe_cnt;
    period(10);
    chk("oot_one_err", 32'(pe_cnt), 32'(pe0 + 1));
    chk("oot_meas13", 32'(last_meas), 13);
    chk("oot_lock_drop_same_cycle", 32'(lock_at_pe), 0);
    chk("oot_err_count", 32'(err_count), 1);
    repeat (3) period(10);
    chk("oot_relock_3", 32'(locked), 0);
    period(12);
    chk("oot_relock_4", 32'(locked), 1);
    period(10);
    chk("oot_12_no_err", 32'(pe_cnt), 32'(pe0 + 1));
    chk("oot_meas12", 32'(last_meas), 12);
    chk("oot_12_locked", 32'(locked), 1);

    // Timeout: 255 counts after the last rise with sig_in held low.
    repeat (248) tick();
    chk("tmo_not_yet", 32'(timeout), 0);
    tick();
    chk("tmo_set", 32'(timeout), 1);
    chk("tmo_err_count", 32'(err_count), 2);
    chk("tmo_unlocked", 32'(locked), 0);
    mv0 = mv_cnt;
    period(10);
    chk("tmo_cleared", 32'(timeout), 0);
    chk("tmo_rearm_no_meas", 32'(mv_cnt), 32'(mv0));
    period(10);
    chk("tmo_next_meas", 32'(mv_cnt), 32'(mv0 + 1));
    chk("tmo_next_meas_val", 32'(last_meas), 10);

    // Error counter saturation then clear coinciding with an error.
    pe0 = pe_cnt;
    repeat (6) period(20);
    chk("sat_errs", 32'(pe_cnt), 32'(pe0 + 5));
    chk("sat_held", 32'(err_count), 3);
    sig_in = 1'b1;
    repeat (3) tick();
    chk("sat_before_clr", 32'(err_count), 3);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("clr_err_pulse", 32'(period_err), 1);
    chk("clr_with_err", 32'(err_count), 1);
    tick();
    sig_in = 1'b0;
    repeat (5) tick();

    // Enable dropped mid-period.
    repeat (5) period(10);
    chk("en_locked_before", 32'(locked), 1);
    mv0 = mv_cnt;
    sig_in = 1'b1;
    repeat (2) tick();
    enable = 1'b0;
    tick();
    chk("en_off_unlocked", 32'(locked), 0);
    chk("en_off_err_kept", 32'(err_count), 1);
    repeat (2) tick();
    chk("en_off_quiet", 32'(mv_cnt), 32'(mv0));
    enable = 1'b1;
    sig_in = 1'b0;
    repeat (5) tick();
    period(10);
    chk("en_first_no_meas", 32'(mv_cnt), 32'(mv0));
    period(10);
    chk("en_second_meas", 32'(mv_cnt), 32'(mv0 + 1));
    chk("en_second_val", 32'(last_meas), 10);

    // Reset mid-period.
    sig_in = 1'b1;
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    chk("mrst_meas_period", 32'(meas_period), 0);
    chk("mrst_err_count", 32'(err_count), 0);
    chk("mrst_locked", 32'(locked), 0);
    chk("mrst_timeout", 32'(timeout), 0);
    chk("mrst_meas_valid", 32'(meas_valid), 0);
    rst_n = 1'b1;
    repeat (3) tick();
    sig_in = 1'b0;
    repeat (5) tick();

    // Asynchronous phase: period 10.3 clk, edges never on a clk edge.
    tolerance = 8'd1;
    #0.25;
    for (int i = 0; i < 22; i++) begin
      if (i == 2) rp_on = 1'b1;
      sig_in = 1'b1;
      #51.3;
      sig_in = 1'b0;
      #51.7;
    end
    rp_on = 1'b0;
    tick();
    chk("rp_count", 32'(rp_cnt), 20);
    chk("rp_min_ge10", 32'(rp_min >= 10), 1);
    chk("rp_max_le11", 32'(rp_max <= 11), 1);

    // Degenerate expected period of 0: every measurement errors.
    exp_period = 8'd0;
    tolerance  = 8'd0;
    pe0 = pe_cnt;
    repeat (3) period(10);
    chk("zero_exp_errs", 32'(pe_cnt), 32'(pe0 + 3));

    chk("no_x_outputs", 32'(x_seen), 0);
    chk("err_only_with_valid", 32'(bad_pe), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
